// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: funct3 opcodes, multiply/divide FSM states and
// the fixed constants the execute stage and its bench rely on.
package riscv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } muldiv_state_e;

    localparam int          MULDIV_LATENCY = 34;
    localparam logic [31:0] DIV0_QUOTIENT  = 32'hFFFFFFFF;
    localparam logic [31:0] SIGNED_MIN     = 32'h80000000;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic opSignedA(input muldiv_op_e o);
        return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
    endfunction

    function automatic logic opSignedB(input muldiv_op_e o);
        return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring steps on
// operand magnitudes, then a sign/select fix-up cycle. Fixed 34-cycle latency.
module riscv_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              signA_q, signA_d;
    logic              signB_q, signB_d;
    logic [XLEN-1:0]   magA_q, magA_d;
    logic [XLEN-1:0]   magB_q, magB_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              isDiv;
    logic              mulBit;
    logic              qBit;
    logic              inSignA, inSignB;
    logic [XLEN:0]     trialRem;
    logic [XLEN+1:0]   addA, addB, addSum;
    logic [XLEN-1:0]   newRem;
    logic [2*XLEN-1:0] stepAcc;
    logic [2*XLEN-1:0] prodSigned;
    logic [XLEN-1:0]   quotient, remainder;
    logic [XLEN-1:0]   fixResult;

    // One shared adder: adds the multiplicand for multiply, subtracts the
    // divisor from the 33-bit trial remainder for divide (borrow = bit XLEN+1).
    always_comb begin
        isDiv    = op_q[2];
        mulBit   = magB_q[count_q];
        trialRem = {acc_q[2*XLEN-1:XLEN], magA_q[~count_q]};
        addA     = '0;
        addB     = '0;
        if (isDiv) begin
            addA = {1'b0, trialRem};
            addB = ~{2'b00, magB_q};
        end else begin
            addA = {2'b00, acc_q[2*XLEN-1:XLEN]};
            addB = mulBit ? {2'b00, magA_q} : '0;
        end
        addSum  = addA + addB + {{(XLEN+1){1'b0}}, isDiv};
        qBit    = ~addSum[XLEN+1];
        newRem  = qBit ? addSum[XLEN-1:0] : trialRem[XLEN-1:0];
        stepAcc = isDiv ? {newRem, acc_q[XLEN-2:0], qBit}
                        : {addSum[XLEN:0], acc_q[XLEN-1:1]};
    end

    // Sign and word selection; only divide-by-zero needs an explicit override,
    // the signed-overflow case falls out of the magnitude arithmetic.
    always_comb begin
        prodSigned = (signA_q ^ signB_q) ? -acc_q : acc_q;
        quotient   = acc_q[XLEN-1:0];
        remainder  = acc_q[2*XLEN-1:XLEN];
        fixResult  = '0;
        case (op_q)
            OP_MUL:                        fixResult = acc_q[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fixResult = prodSigned[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (magB_q == '0)
                    fixResult = DIV0_QUOTIENT;
                else
                    fixResult = (signA_q ^ signB_q) ? -quotient : quotient;
            end
            default:                       fixResult = signA_q ? -remainder : remainder;
        endcase
    end

    always_comb begin
        inSignA  = opSignedA(muldiv_op_e'(op)) & A[XLEN-1];
        inSignB  = opSignedB(muldiv_op_e'(op)) & B[XLEN-1];
        state_d  = state_q;
        op_d     = op_q;
        signA_d  = signA_q;
        signB_d  = signB_q;
        magA_d   = magA_q;
        magB_d   = magB_q;
        acc_d    = acc_q;
        count_d  = count_q;
        result_d = result_q;
        case (state_q)
            CALC: begin
                acc_d   = stepAcc;
                count_d = count_q + 1'b1;
                if (count_q == LAST_STEP)
                    state_d = FIX;
            end
            FIX: begin
                result_d = fixResult;
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (((state_q == IDLE) || (state_q == DONE)) && start) begin
            op_d    = muldiv_op_e'(op);
            signA_d = inSignA;
            signB_d = inSignB;
            magA_d  = inSignA ? -A : A;
            magB_d  = inSignB ? -B : B;
            acc_d   = '0;
            count_d = '0;
            state_d = CALC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            signA_q  <= 1'b0;
            signB_q  <= 1'b0;
            magA_q   <= '0;
            magB_q   <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            signA_q  <= signA_d;
            signB_q  <= signB_d;
            magA_q   <= magA_d;
            magB_q   <= magB_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign Result = result_q;
    assign Zero   = (result_q == '0);

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: directed RV32M vectors push expected
// results; an independent monitor checks every done pulse against the queue.
module tb_riscv_muldiv;
    import riscv_pkg::*;

    typedef struct {
        logic [31:0] result;
        int          acceptEdge;
    } expect_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, Zero;
    logic [31:0] Result;

    int      cycle = 0;
    int      checks = 0;
    int      fails = 0;
    logic    prevDone = 1'b0;
    expect_t sbQ[$];

    riscv_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .Zero   (Zero)
    );

    // Free-running clock and a posedge counter used to time latency
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // Drive one request at the current negedge; the next posedge accepts it
    task automatic applyStimulus(input muldiv_op_e o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected);
        expect_t e;
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        e.result     = expected;
        e.acceptEdge = cycle + 1;
        sbQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL timeout: %0d results outstanding, expected 0", sbQ.size());
            sbQ.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            checkOutput("doneWidth", {31'b0, prevDone}, 32'd0);
            checkOutput("busyOnDone", {31'b0, busy}, 32'd0);
            if (sbQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL unexpectedDone: got done=1 with Result 0x%08h, expected no done", Result);
            end else begin
                expect_t e;
                e = sbQ.pop_front();
                checkOutput("result", Result, e.result);
                checkOutput("zero", {31'b0, Zero}, {31'b0, (e.result == 32'd0)});
                checkOutput("latency", 32'(cycle - e.acceptEdge), 32'(MULDIV_LATENCY - 1));
            end
        end
        prevDone <= done;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawDone;
        int   n;
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetResult", Result, 32'd0);
        checkOutput("resetZero", {31'b0, Zero}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors: multiply halves, division signs, special cases
        applyStimulus(OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB); waitIdle();
        applyStimulus(OP_MULH,   32'h80000000,   32'h80000000, 32'h40000000); waitIdle();
        applyStimulus(OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE); waitIdle();
        applyStimulus(OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF); waitIdle();
        applyStimulus(OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000); waitIdle();
        applyStimulus(OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD); waitIdle();
        applyStimulus(OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF); waitIdle();
        applyStimulus(OP_DIVU,   32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC); waitIdle();
        applyStimulus(OP_REMU,   32'd10,         32'd3,        32'd1);        waitIdle();
        applyStimulus(OP_DIV,    32'd5,          32'd0,        DIV0_QUOTIENT); waitIdle();
        applyStimulus(OP_REMU,   32'd5,          32'd0,        32'd5);        waitIdle();
        applyStimulus(OP_DIV,    32'hFFFFFFFB,   32'd0,        DIV0_QUOTIENT); waitIdle();
        applyStimulus(OP_REM,    32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB); waitIdle();
        applyStimulus(OP_DIV,    SIGNED_MIN,     32'hFFFFFFFF, SIGNED_MIN);   waitIdle();
        applyStimulus(OP_REM,    SIGNED_MIN,     32'hFFFFFFFF, 32'd0);        waitIdle();

        // Start pulsed mid-operation must be ignored
        applyStimulus(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        repeat (4) @(negedge clk);
        op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        checkOutput("ignoredStartIdle", {31'b0, busy}, 32'd0);
        checkOutput("ignoredStartResult", Result, 32'hFFFFFFFE);

        // Start in the DONE cycle is accepted back-to-back
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd14);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        applyStimulus(OP_REMU, 32'd100, 32'd7, 32'd2);
        waitIdle();

        // Reset in the middle of a divide discards the operation
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd14);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sbQ.delete();
        @(negedge clk);
        checkOutput("midResetBusy", {31'b0, busy}, 32'd0);
        checkOutput("midResetResult", Result, 32'd0);
        checkOutput("midResetZero", {31'b0, Zero}, 32'd1);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(negedge clk);
            sawDone = sawDone | done;
        end
        checkOutput("noDoneAfterReset", {31'b0, sawDone}, 32'd0);

        applyStimulus(OP_MUL, 32'd12345, 32'd100, 32'h0012D644);
        waitIdle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
